// File: rtl/uart_stream_bridge.sv
`default_nettype none
// uart_stream_bridge: 8N1 serial pins <-> 8-bit valid/ready byte streams, with a small RX byte FIFO.
// Revision 1.0
module uart_stream_bridge #(
  parameter int CLK_DIV       = 417,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic       clk_48mhz,
  input  logic       resetn,
  input  logic       ser_tx,
  output logic       ser_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam int AW = $clog2(RX_FIFO_DEPTH);
  localparam logic [CW-1:0] BIT_CNT  = CW'(CLK_DIV);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLK_DIV / 2);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(RX_FIFO_DEPTH);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  logic          sync_meta, sync_rx;
  rx_state_t     rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_idx;
  logic [7:0]    rx_shift;
  logic [7:0]    mem [RX_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  tx_state_t     tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_idx;
  logic [7:0]    tx_shift;

  // A counter "reaches 0" on the cycle it would decrement from 1, so each bit lasts exactly CLK_DIV cycles.
  logic rx_tick, tx_tick, full, pop, push;
  assign rx_tick  = (rx_cnt == ONE_CNT);
  assign tx_tick  = (tx_cnt == ONE_CNT);
  assign full     = (count == FULL_CNT);
  assign rx_valid = (count != '0);
  assign rx_data  = mem[rd_ptr];
  assign pop      = rx_valid && rx_ready;
  assign push     = (rx_state == RX_STOP) && rx_tick && sync_rx && (!full || pop);

  always_ff @(posedge clk_48mhz or negedge resetn) begin
    if (!resetn) begin
      sync_meta <= 1'b1;
      sync_rx   <= 1'b1;
    end else begin
      sync_meta <= ser_tx;
      sync_rx   <= sync_meta;
    end
  end

  always_ff @(posedge clk_48mhz or negedge resetn) begin
    if (!resetn) begin
      rx_state  <= RX_IDLE;
      rx_cnt    <= '0;
      rx_idx    <= '0;
      rx_shift  <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (!sync_rx) begin
            rx_cnt   <= HALF_CNT;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_tick) begin
            if (sync_rx) begin
              rx_state <= RX_IDLE;
            end else begin
              rx_cnt   <= BIT_CNT;
              rx_idx   <= '0;
              rx_state <= RX_DATA;
            end
          end else begin
            rx_cnt <= rx_cnt - ONE_CNT;
          end
        end
        RX_DATA: begin
          if (rx_tick) begin
            rx_shift <= {sync_rx, rx_shift[7:1]};
            rx_cnt   <= BIT_CNT;
            rx_idx   <= rx_idx + 3'd1;
            if (rx_idx == 3'd7) rx_state <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt - ONE_CNT;
          end
        end
        RX_STOP: begin
          if (rx_tick) begin
            if (sync_rx) begin
              rx_state <= RX_IDLE;
              if (!push) overrun <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              rx_state  <= RX_BREAK;
            end
          end else begin
            rx_cnt <= rx_cnt - ONE_CNT;
          end
        end
        RX_BREAK: begin
          if (sync_rx) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_48mhz or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < RX_FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= rx_shift;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_48mhz or negedge resetn) begin
    if (!resetn) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      ser_rx   <= 1'b1;
      tx_ready <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (tx_valid && tx_ready) begin
            tx_shift <= tx_data;
            ser_rx   <= 1'b0;
            tx_cnt   <= BIT_CNT;
            tx_ready <= 1'b0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_tick) begin
            ser_rx   <= tx_shift[0];
            tx_cnt   <= BIT_CNT;
            tx_idx   <= '0;
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt - ONE_CNT;
          end
        end
        TX_DATA: begin
          if (tx_tick) begin
            tx_cnt <= BIT_CNT;
            if (tx_idx == 3'd7) begin
              ser_rx   <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              ser_rx   <= tx_shift[1];
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx_idx   <= tx_idx + 3'd1;
            end
          end else begin
            tx_cnt <= tx_cnt - ONE_CNT;
          end
        end
        TX_STOP: begin
          if (tx_tick) begin
            tx_ready <= 1'b1;
            tx_state <= TX_IDLE;
          end else begin
            tx_cnt <= tx_cnt - ONE_CNT;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_stream_bridge.sv
`default_nettype none
// Directed bench for uart_stream_bridge at CLK_DIV=16, RX_FIFO_DEPTH=4.
module tb_uart_stream_bridge;

  localparam int DIV = 16;

  logic       clk_48mhz = 1'b0;
  logic       resetn    = 1'b0;
  logic       ser_tx    = 1'b1;
  logic       ser_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready  = 1'b0;
  logic [7:0] tx_data   = 8'h00;
  logic       tx_valid  = 1'b0;
  logic       tx_ready;
  logic       frame_err;
  logic       overrun;

  uart_stream_bridge #(.CLK_DIV(DIV), .RX_FIFO_DEPTH(4)) dut (
    .clk_48mhz(clk_48mhz), .resetn(resetn), .ser_tx(ser_tx), .ser_rx(ser_rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk_48mhz = ~clk_48mhz;

  int checks = 0;
  int passes = 0;

  // Pop log and pulse counters, written only by this monitor.
  logic [7:0] rx_log [0:63];
  int rx_n = 0, valid_cycles = 0, fe_cnt = 0, ov_cnt = 0;
  always @(negedge clk_48mhz) begin
    if (rx_valid && rx_ready && rx_n < 64) begin
      rx_log[rx_n] = rx_data;
      rx_n++;
    end
    if (rx_valid) valid_cycles++;
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_48mhz);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      ser_tx = f[i];
      idle(DIV);
    end
    ser_tx = 1'b1;
  endtask

  // Sends one byte through the TX path and checks every cycle of the resulting serial frame.
  task automatic check_tx(input logic [7:0] b, input string tag);
    int i, bad, k;
    logic expv;
    tx_data  = b;
    tx_valid = 1'b1;
    idle(1);
    tx_valid = 1'b0;
    tx_data  = ~b;
    i = 0;
    bad = 0;
    while (tx_ready === 1'b0 && i < 400) begin
      k = i / DIV;
      if (k == 0) expv = 1'b0;
      else if (k <= 8) expv = b[k-1];
      else expv = 1'b1;
      if (ser_rx !== expv) bad++;
      i++;
      idle(1);
    end
    chk({tag, "_low_cycles"}, i, 10 * DIV);
    chk({tag, "_wave_errs"}, bad, 0);
    chk({tag, "_idle_line"}, ser_rx, 1'b1);
  endtask

  int n0, fe0, ov0, v0;

  initial begin
    // Reset values
    idle(3);
    chk("rst_ser_rx", ser_rx, 1'b1);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_tx_ready", tx_ready, 1'b1);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    resetn = 1'b1;
    idle(5);

    // RX 0xA5 with consumer ready
    rx_ready = 1'b1;
    n0 = rx_n; v0 = valid_cycles; fe0 = fe_cnt; ov0 = ov_cnt;
    send_frame(8'hA5, 1'b1);
    idle(20);
    chk("a5_count", rx_n - n0, 1);
    chk("a5_data", rx_log[n0], 8'hA5);
    chk("a5_valid_cycles", valid_cycles - v0, 1);
    chk("a5_frame_err", fe_cnt - fe0, 0);
    chk("a5_overrun", ov_cnt - ov0, 0);

    // TX 0x3C
    check_tx(8'h3C, "tx3c");

    // FIFO fill and overrun
    rx_ready = 1'b0;
    n0 = rx_n; ov0 = ov_cnt;
    for (int b = 1; b <= 4; b++) begin
      send_frame(8'(b), 1'b1);
      idle(10);
    end
    chk("fill_no_overrun", ov_cnt - ov0, 0);
    chk("fill_valid", rx_valid, 1'b1);
    chk("fill_head", rx_data, 8'h01);
    send_frame(8'h05, 1'b1);
    idle(10);
    chk("fill_overrun", ov_cnt - ov0, 1);
    chk("fill_head_kept", rx_data, 8'h01);
    rx_ready = 1'b1;
    idle(10);
    chk("drain_count", rx_n - n0, 4);
    chk("drain_0", rx_log[n0],     8'h01);
    chk("drain_1", rx_log[n0 + 1], 8'h02);
    chk("drain_2", rx_log[n0 + 2], 8'h03);
    chk("drain_3", rx_log[n0 + 3], 8'h04);
    chk("drain_empty", rx_valid, 1'b0);

    // Framing error followed by held break
    n0 = rx_n; fe0 = fe_cnt;
    send_frame(8'h55, 1'b0);
    ser_tx = 1'b0;
    idle(100);
    ser_tx = 1'b1;
    idle(20);
    chk("break_fe_once", fe_cnt - fe0, 1);
    chk("break_no_push", rx_n - n0, 0);
    send_frame(8'h7E, 1'b1);
    idle(20);
    chk("after_break_count", rx_n - n0, 1);
    chk("after_break_data", rx_log[n0], 8'h7E);
    chk("after_break_fe", fe_cnt - fe0, 1);

    // Start-bit glitch rejection
    n0 = rx_n; fe0 = fe_cnt; ov0 = ov_cnt;
    ser_tx = 1'b0;
    idle(4);
    ser_tx = 1'b1;
    idle(40);
    chk("glitch_no_byte", rx_n - n0, 0);
    chk("glitch_no_fe", fe_cnt - fe0, 0);
    send_frame(8'h81, 1'b1);
    idle(20);
    chk("glitch_then_count", rx_n - n0, 1);
    chk("glitch_then_data", rx_log[n0], 8'h81);
    chk("glitch_then_ov", ov_cnt - ov0, 0);

    // Asynchronous reset mid-frame on both paths
    rx_ready = 1'b0;
    send_frame(8'h42, 1'b1);
    idle(10);
    chk("pre_rst_valid", rx_valid, 1'b1);
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    idle(1);
    tx_valid = 1'b0;
    ser_tx   = 1'b0;
    idle(60);
    chk("pre_rst_ser_rx_low", ser_rx, 1'b0);
    #2 resetn = 1'b0;
    #1;
    chk("async_ser_rx", ser_rx, 1'b1);
    chk("async_rx_valid", rx_valid, 1'b0);
    chk("async_tx_ready", tx_ready, 1'b1);
    idle(3);
    ser_tx = 1'b1;
    idle(2);
    resetn = 1'b1;
    idle(5);
    chk("post_rst_tx_ready", tx_ready, 1'b1);
    chk("post_rst_rx_valid", rx_valid, 1'b0);
    rx_ready = 1'b1;
    check_tx(8'hFF, "txff");
    n0 = rx_n; fe0 = fe_cnt;
    send_frame(8'h00, 1'b1);
    idle(20);
    chk("post_rst_rx_count", rx_n - n0, 1);
    chk("post_rst_rx_data", rx_log[n0], 8'h00);
    chk("post_rst_rx_fe", fe_cnt - fe0, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_stream_bridge.md
Name: uart_stream_bridge

Overview:
- Bridges the SoC's 8N1 serial pins (ser_tx / ser_rx) to the 8-bit valid/ready byte pipeline of usb_uart.
- RX path: deserialises ser_tx into a small byte FIFO that drives usb_uart's uart_in stream.
- TX path: serialises bytes from usb_uart's uart_out stream onto ser_rx.
- Sits between the picosoc simpleuart pins and usb_uart inside the TinyFPGA top level. It replaces the current byte loopback.

Parameters:
- CLK_DIV, 417, clk_48mhz cycles per bit. Range 16..65535. 417 gives ~115200 baud at 48 MHz.
- RX_FIFO_DEPTH, 4, RX byte FIFO entries. Power of two, at least 2.

Ports:
- clk_48mhz  in  1  sole clock.
- resetn  in  1  reset. Asynchronous assert, active-low.
- ser_tx  in  1  serial line from the SoC, idle high, asynchronous to clk_48mhz.
- ser_rx  out  1  serial line to the SoC, idle high.
- rx_data  out  8  received byte, to uart_in_data.
- rx_valid  out  1  rx_data valid.
- rx_ready  in  1  consumer accepts rx_data.
- tx_data  in  8  byte to transmit, from uart_out_data.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  bridge accepts tx_data.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: received byte dropped because the FIFO was full.

Behaviour:
- Reset (resetn low, asynchronous):
  - ser_rx=1, rx_valid=0, rx_data=0, tx_ready=1, frame_err=0, overrun=0.
  - FIFO empty; both FSMs in IDLE; synchroniser flops preset to 1.
- Clocking and counters:
  - All state changes on posedge clk_48mhz.
  - Bit counters are $clog2(CLK_DIV+1) bits wide and count down to 0. They never wrap.
- ser_tx synchroniser: 2 flops; the RX FSM sees only the second flop (sync_rx).
- RX FSM:
  - IDLE: on sync_rx=0, load counter with CLK_DIV/2 (integer division) and go to START.
  - START: when counter reaches 0, sample sync_rx.
    - If 1, treat as a glitch and return to IDLE.
    - If 0, load CLK_DIV and go to DATA with bit index 0.
  - DATA: each time counter reaches 0, shift sync_rx into bit[index] (LSB first) and reload CLK_DIV. After index 7 is sampled, go to STOP.
  - STOP: when counter reaches 0, sample sync_rx.
    - If 1: push the byte into the FIFO, go to IDLE.
    - If 0: pulse frame_err, drop the byte, go to BREAK.
  - BREAK: stay until sync_rx=1, then go to IDLE. A held break line produces exactly one frame_err.
- RX FIFO:
  - rx_valid = not empty. rx_data = head entry, held stable while rx_valid && !rx_ready.
  - A pop happens on a cycle with rx_valid && rx_ready.
  - Push accepted if not full, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overrun pulses for 1 cycle. FIFO contents are unchanged.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Latency: rx_valid rises 1 cycle after the STOP sample when the FIFO was empty.
- TX FSM:
  - IDLE: tx_ready=1. On tx_valid && tx_ready, latch tx_data, drive ser_rx=0, load CLK_DIV, go to START. tx_ready=0 from the next cycle.
  - START: hold ser_rx=0 for CLK_DIV cycles, then go to DATA.
  - DATA: drive bit0..bit7 LSB first, each for CLK_DIV cycles.
  - STOP: hold ser_rx=1 for CLK_DIV cycles, then go to IDLE.
  - ser_rx is registered. A frame is exactly 10*CLK_DIV cycles from the start-bit edge to tx_ready re-asserting.
  - tx_data may change after acceptance without effect. A back-to-back byte is accepted on the first IDLE cycle, so stop and the next start bit are contiguous.
- RX and TX are fully independent; simultaneous activity is allowed.
- resetn asserted mid-frame:
  - Immediately: ser_rx=1, in-flight bytes lost, FIFO emptied.
  - After release, the RX FSM waits in IDLE for a falling edge. A line already low is taken as a start bit and is checked in START.

Test Plan:
- CLK_DIV=16, drive 8N1 frame 0xA5 on ser_tx, rx_ready=1 -> rx_data=0xA5 with rx_valid high exactly 1 cycle; frame_err=0, overrun=0.
- CLK_DIV=16, tx_data=0x3C with tx_valid pulsed -> ser_rx low 16 cycles, then bits 0,0,1,1,1,1,0,0 each 16 cycles, then high 16 cycles; tx_ready low for exactly 160 cycles.
- rx_ready=0, send 5 frames 0x01..0x05 with RX_FIFO_DEPTH=4 -> overrun pulses once, at the 5th stop sample; then raising rx_ready pops 0x01,0x02,0x03,0x04 in order and rx_valid drops.
- Frame 0x55 with stop bit low, then line held low 100 cycles, then high -> one frame_err pulse, no FIFO push; a following valid frame 0x7E is received correctly.
- 4-cycle low glitch on idle ser_tx (CLK_DIV=16) -> START rejects it, no byte, no error; then a correct frame 0x81 is received.
- Assert resetn mid-TX and mid-RX frame -> ser_rx=1 and rx_valid=0 asynchronously; after release, tx_ready=1, and the next frames 0xFF (TX) and 0x00 (RX) complete correctly.
